// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: owner encoding, size codes, lock states.
// Build option: SRAM_ARB_RR_EN selects round-robin instead of fixed data priority.
package sram_like_arbiter_pkg;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// 1-bit in-order owner FIFO; head is read combinationally so responses route with zero latency.
module sram_arb_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_din,
   input  logic                     i_pop,
   output logic                     o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between IF (inst_*) and MEM (data_*) requesters, routing responses in order.
// Build option: SRAM_ARB_RR_EN enables round-robin when both request while unlocked.
module sram_like_arbiter
   import sram_like_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [3:0]        inst_wstrb,
   input  logic [31:0]       inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [31:0]       inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [3:0]        data_wstrb,
   input  logic [31:0]       data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [31:0]       data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [31:0]       mem_rdata,
   output logic              resp_err
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   lock_state_t   r_state;
   logic          r_lock_owner;
   logic          r_resp_err;
`ifdef SRAM_ARB_RR_EN
   logic          r_last_grant;
`endif

   logic          w_grant_valid;
   logic          w_grant_owner;
   logic          w_owner_req;
   logic          w_accept;
   logic          w_resp;
   logic          w_fifo_head;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [CW-1:0] w_fifo_count;

   // Issue is gated on the registered count only, never on this cycle's data_ok.
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_owner = OWNER_INST;
      if (!rst) begin
         if (r_state == LOCKED) begin
            w_grant_valid = 1'b1;
            w_grant_owner = r_lock_owner;
         end else if (!w_fifo_full) begin
            if (data_req && inst_req) begin
               w_grant_valid = 1'b1;
`ifdef SRAM_ARB_RR_EN
               w_grant_owner = ~r_last_grant;
`else
               w_grant_owner = OWNER_DATA;
`endif
            end else if (data_req) begin
               w_grant_valid = 1'b1;
               w_grant_owner = OWNER_DATA;
            end else if (inst_req) begin
               w_grant_valid = 1'b1;
               w_grant_owner = OWNER_INST;
            end
         end
      end
   end

   assign w_owner_req  = (w_grant_owner == OWNER_DATA) ? data_req : inst_req;
   assign mem_req      = w_grant_valid & w_owner_req;
   assign w_accept     = mem_req & mem_addr_ok;
   assign inst_addr_ok = w_accept & (w_grant_owner == OWNER_INST);
   assign data_addr_ok = w_accept & (w_grant_owner == OWNER_DATA);

   assign mem_wr    = (w_grant_owner == OWNER_DATA) ? data_wr    : inst_wr;
   assign mem_size  = (w_grant_owner == OWNER_DATA) ? data_size  : inst_size;
   assign mem_addr  = (w_grant_owner == OWNER_DATA) ? data_addr  : inst_addr;
   assign mem_wstrb = (w_grant_owner == OWNER_DATA) ? data_wstrb : inst_wstrb;
   assign mem_wdata = (w_grant_owner == OWNER_DATA) ? data_wdata : inst_wdata;

   assign w_resp       = !rst & mem_data_ok & (w_fifo_count != '0);
   assign inst_data_ok = w_resp & (w_fifo_head == OWNER_INST);
   assign data_data_ok = w_resp & (w_fifo_head == OWNER_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;
   assign resp_err     = r_resp_err;

   // A dropped owner req while locked is a protocol violation; just release the lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= UNLOCKED;
         r_lock_owner <= OWNER_INST;
      end else begin
         case (r_state)
            UNLOCKED: begin
               if (mem_req && !mem_addr_ok) begin
                  r_state      <= LOCKED;
                  r_lock_owner <= w_grant_owner;
               end
            end
            LOCKED: begin
               if (!mem_req || mem_addr_ok) begin
                  r_state <= UNLOCKED;
               end
            end
            default: r_state <= UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_err <= 1'b0;
      end else if (mem_data_ok && w_fifo_empty) begin
         r_resp_err <= 1'b1;
      end
   end

`ifdef SRAM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= OWNER_INST;
      end else if (w_accept) begin
         r_last_grant <= w_grant_owner;
      end
   end
`endif

   sram_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept),
      .i_din   (w_grant_owner),
      .i_pop   (w_resp),
      .o_head  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (default build: fixed data priority, 4 outstanding).
module tb_sram_like_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, mem_size;
   logic [31:0] inst_addr, data_addr, mem_addr;
   logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
   logic [31:0] inst_wdata, data_wdata, mem_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata, mem_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(.MAX_OUTSTANDING(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .resp_err(resp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen 4 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
   endtask

   initial begin
      idle();
      rst = 1;
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      step(); step();
      #4;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_inst_data_ok", inst_data_ok, 0);
      chk("rst_data_data_ok", data_data_ok, 0);
      chk("rst_resp_err", resp_err, 0);
      step();
      rst = 0; idle();
      #4;
      chk("idle_mem_req", mem_req, 0);
      step();

      // single inst read
      inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
      #4;
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'h1c000000);
      chk("t1_inst_addr_ok", inst_addr_ok, 1);
      chk("t1_data_addr_ok", data_addr_ok, 0);
      step(); idle();
      #4;
      chk("t1_c1_inst_data_ok", inst_data_ok, 0);
      step();
      mem_data_ok = 1; mem_rdata = 32'h02800000;
      #4;
      chk("t1_inst_data_ok", inst_data_ok, 1);
      chk("t1_data_data_ok", data_data_ok, 0);
      chk("t1_inst_rdata", inst_rdata, 32'h02800000);
      step(); idle();

      // both request: data (a write) first, inst next
      inst_req = 1; inst_addr = 32'h1c000010;
      data_req = 1; data_addr = 32'h80001000; data_wr = 1; data_size = 2'd2;
      data_wstrb = 4'hf; data_wdata = 32'hdeadbeef;
      mem_addr_ok = 1;
      #4;
      chk("t2_mem_addr_data", mem_addr, 32'h80001000);
      chk("t2_mem_wr", mem_wr, 1);
      chk("t2_mem_wstrb", mem_wstrb, 4'hf);
      chk("t2_mem_wdata", mem_wdata, 32'hdeadbeef);
      chk("t2_data_addr_ok", data_addr_ok, 1);
      chk("t2_inst_addr_ok0", inst_addr_ok, 0);
      step();
      data_req = 0; data_wr = 0;
      #4;
      chk("t2_mem_addr_inst", mem_addr, 32'h1c000010);
      chk("t2_inst_addr_ok", inst_addr_ok, 1);
      step(); idle();
      mem_data_ok = 1; mem_rdata = 32'h11111111;
      #4;
      chk("t2_r0_data_data_ok", data_data_ok, 1);
      chk("t2_r0_inst_data_ok", inst_data_ok, 0);
      step();
      #4;
      chk("t2_r1_inst_data_ok", inst_data_ok, 1);
      chk("t2_r1_data_data_ok", data_data_ok, 0);
      step(); idle();

      // lock: inst held 3 cycles without acceptance, data arrives meanwhile
      inst_req = 1; inst_addr = 32'h1c000020;
      #4;
      chk("t3_c0_mem_addr", mem_addr, 32'h1c000020);
      chk("t3_c0_inst_addr_ok", inst_addr_ok, 0);
      step();
      data_req = 1; data_addr = 32'h80002000;
      #4;
      chk("t3_c1_mem_addr", mem_addr, 32'h1c000020);
      chk("t3_c1_data_addr_ok", data_addr_ok, 0);
      step();
      #4;
      chk("t3_c2_mem_addr", mem_addr, 32'h1c000020);
      step();
      mem_addr_ok = 1;
      #4;
      chk("t3_c3_inst_addr_ok", inst_addr_ok, 1);
      chk("t3_c3_data_addr_ok", data_addr_ok, 0);
      step();
      inst_req = 0;
      #4;
      chk("t3_c4_mem_addr", mem_addr, 32'h80002000);
      chk("t3_c4_data_addr_ok", data_addr_ok, 1);
      step(); idle();
      mem_data_ok = 1;
      #4;
      chk("t3_r0_inst_data_ok", inst_data_ok, 1);
      step();
      #4;
      chk("t3_r1_data_data_ok", data_data_ok, 1);
      step(); idle();

      // fill to MAX_OUTSTANDING
      inst_req = 1; mem_addr_ok = 1;
      for (int i = 0; i < 4; i++) begin
         inst_addr = 32'h1c000100 + 32'(i * 4);
         #4;
         chk($sformatf("t4_issue%0d_addr_ok", i), inst_addr_ok, 1);
         step();
      end
      inst_addr = 32'h1c000110;
      mem_data_ok = 1;
      #4;
      chk("t4_full_mem_req", mem_req, 0);
      chk("t4_full_inst_addr_ok", inst_addr_ok, 0);
      chk("t4_full_inst_data_ok", inst_data_ok, 1);
      step();
      mem_data_ok = 0;
      #4;
      chk("t4_reissue_mem_req", mem_req, 1);
      chk("t4_reissue_addr_ok", inst_addr_ok, 1);
      step();
      inst_req = 0; mem_data_ok = 1;
      for (int i = 0; i < 4; i++) begin
         #4;
         chk($sformatf("t4_drain%0d_inst_data_ok", i), inst_data_ok, 1);
         step();
      end
      idle();

      // interleaved inst, data, inst
      mem_addr_ok = 1;
      inst_req = 1; step();
      inst_req = 0; data_req = 1; step();
      data_req = 0; inst_req = 1; step();
      idle();
      mem_data_ok = 1;
      #4;
      chk("t5_r0_inst", {inst_data_ok, data_data_ok}, 2'b10);
      step();
      #4;
      chk("t5_r1_data", {inst_data_ok, data_data_ok}, 2'b01);
      step();
      #4;
      chk("t5_r2_inst", {inst_data_ok, data_data_ok}, 2'b10);
      chk("t5_r2_resp_err", resp_err, 0);
      step();

      // FIFO now empty: this pulse is spurious
      #4;
      chk("t6_empty_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      chk("t6_err_not_yet", resp_err, 0);
      step(); idle();
      #4;
      chk("t6_resp_err_set", resp_err, 1);
      step();
      #4;
      chk("t6_resp_err_sticky", resp_err, 1);
      rst = 1;
      step();
      rst = 0;
      #4;
      chk("t6_resp_err_cleared", resp_err, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
